// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: default widths and bus-slicing helper.
// Used by the register file and its scoreboard.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    // Widest packed bus and widest field the slicing helper handles.
    localparam int BUS_W   = 512;
    localparam int SLICE_W = 64;

    function automatic logic [SLICE_W-1:0] slice(
        input logic [BUS_W-1:0] bus,
        input int               idx,
        input int               w
    );
        return SLICE_W'(bus >> (idx * w));
    endfunction

endpackage

// File: rtl/regfile_sb_core.sv
// Per-register busy scoreboard: set at issue, cleared at writeback.
// A set and a clear on the same register in one cycle leaves it set.
module regfile_sb_core
    import rv_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] nxt;
    logic [AW-1:0]    wa;

    always_comb begin
        nxt = busy;
        wa  = '0;
        for (int w = 0; w < NWR; w++) begin
            wa = AW'(slice(BUS_W'(wr_addr), w, AW));
            if (wr_en[w])
                nxt[wa] = 1'b0;
        end
        if (iss_en)
            nxt[iss_addr] = 1'b1;
        if (ZERO_REG != 0)
            nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= nxt;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass
// and a RAW busy scoreboard for decode.
module regfile_mp_sb
    import rv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   ra   [NRD];
    logic [AW-1:0]   wa   [NWR];
    logic [XLEN-1:0] wd   [NWR];
    logic [XLEN-1:0] d;
    logic            b;

    always_comb begin
        for (int p = 0; p < NRD; p++)
            ra[p] = AW'(slice(BUS_W'(rd_addr), p, AW));
        for (int w = 0; w < NWR; w++) begin
            wa[w] = AW'(slice(BUS_W'(wr_addr), w, AW));
            wd[w] = XLEN'(slice(BUS_W'(wr_data), w, XLEN));
        end
    end

    // Later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] &&
                    !(ZERO_REG != 0 && wa[w] == AW'(REG_ZERO)))
                    regs[wa[w]] <= wd[w];
        end
    end

    regfile_sb_core #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy_vec)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        d       = '0;
        b       = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            d = regs[ra[p]];
            b = busy_vec[ra[p]];
            if (BYPASS != 0)
                for (int w = 0; w < NWR; w++)
                    if (wr_en[w] && wa[w] == ra[p]) begin
                        d = wd[w];
                        b = 1'b0;
                    end
            if (ZERO_REG != 0 && ra[p] == AW'(REG_ZERO)) begin
                d = '0;
                b = 1'b0;
            end
            // Forwarded write data must not leak out while in reset.
            if (rst) begin
                d = '0;
                b = 1'b0;
            end
            rd_data[p*XLEN +: XLEN] = d;
            rd_busy[p]              = b;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: bypass, zero register,
// scoreboard lifecycle, port conflicts and asynchronous reset.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst;

    logic [14:0] a_rd_addr;
    logic [95:0] a_rd_data;
    logic [2:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_iss_en;
    logic [4:0]  a_iss_addr;
    logic [31:0] a_busy_vec;

    logic [4:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic        b_rd_busy;
    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_iss_en;
    logic [4:0]  b_iss_addr;
    logic [31:0] b_busy_vec;

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    regfile_mp_sb #(
        .NRD (3), .NWR (2), .BYPASS (1), .ZERO_REG (1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (a_rd_addr),
        .rd_data  (a_rd_data),
        .rd_busy  (a_rd_busy),
        .wr_en    (a_wr_en),
        .wr_addr  (a_wr_addr),
        .wr_data  (a_wr_data),
        .iss_en   (a_iss_en),
        .iss_addr (a_iss_addr),
        .busy_vec (a_busy_vec)
    );

    regfile_mp_sb #(
        .NRD (1), .NWR (1), .BYPASS (0), .ZERO_REG (1)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_busy  (b_rd_busy),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .iss_en   (b_iss_en),
        .iss_addr (b_iss_addr),
        .busy_vec (b_busy_vec)
    );

    function automatic logic [31:0] obs(int sel);
        case (sel)
            0, 1, 2: return a_rd_data[sel*32 +: 32];
            3, 4, 5: return {31'b0, a_rd_busy[sel-3]};
            6:       return a_busy_vec;
            7:       return b_rd_data;
            8:       return b_busy_vec;
            default: return {31'b0, b_rd_busy};
        endcase
    endfunction

    task automatic push(string tag, int sel, logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        q.push_back(x);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.sel);
            vectors++;
            assert (o === e.exp) else begin
                errs++;
                $error("FAIL %s observed=%h expected=%h",
                       e.tag, o, e.exp);
            end
        end
    endtask

    task automatic idle();
        a_rd_addr  = '0;
        a_wr_en    = '0;
        a_wr_addr  = '0;
        a_wr_data  = '0;
        a_iss_en   = 1'b0;
        a_iss_addr = '0;
        b_rd_addr  = '0;
        b_wr_en    = 1'b0;
        b_wr_addr  = '0;
        b_wr_data  = '0;
        b_iss_en   = 1'b0;
        b_iss_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic awr(int port, logic [4:0] a, logic [31:0] d);
        a_wr_en[port]           = 1'b1;
        a_wr_addr[port*5 +: 5]  = a;
        a_wr_data[port*32 +: 32] = d;
    endtask

    task automatic ard(int port, logic [4:0] a);
        a_rd_addr[port*5 +: 5] = a;
    endtask

    task automatic aiss(logic [4:0] a);
        a_iss_en   = 1'b1;
        a_iss_addr = a;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        push("rst_rd0", 0, 32'h0);
        push("rst_busy0", 3, 32'h0);
        push("rst_bvec", 6, 32'h0);
        push("rst_b_bvec", 8, 32'h0);
        check();
        #5;
        rst = 1'b0;

        // Bypass on A, no bypass on B
        tick();
        awr(0, 5'd3, 32'h1234_5678);
        ard(0, 5'd3);
        b_wr_en   = 1'b1;
        b_wr_addr = 5'd3;
        b_wr_data = 32'h1234_5678;
        b_rd_addr = 5'd3;
        #1;
        push("byp_data", 0, 32'h1234_5678);
        push("byp_busy", 3, 32'h0);
        push("nobyp_old", 7, 32'h0);
        check();
        tick();
        ard(0, 5'd3);
        b_rd_addr = 5'd3;
        #1;
        push("byp_stored", 0, 32'h1234_5678);
        push("nobyp_next", 7, 32'h1234_5678);
        check();

        // Zero register
        tick();
        awr(0, 5'd0, 32'hFFFF_FFFF);
        aiss(5'd0);
        ard(0, 5'd0);
        #1;
        push("x0_comb", 0, 32'h0);
        check();
        tick();
        ard(0, 5'd0);
        #1;
        push("x0_stored", 0, 32'h0);
        push("x0_bvec", 6, 32'h0);
        check();

        // Scoreboard lifecycle on x10
        aiss(5'd10);
        tick();
        ard(1, 5'd10);
        #1;
        push("sb_set", 6, 32'h0000_0400);
        push("sb_rdbusy", 4, 32'h1);
        check();
        tick();
        tick();
        awr(0, 5'd10, 32'h55);
        ard(0, 5'd10);
        #1;
        push("sb_wb_data", 0, 32'h55);
        push("sb_wb_busy", 3, 32'h0);
        push("sb_wb_bvec", 6, 32'h0000_0400);
        check();
        tick();
        ard(0, 5'd10);
        #1;
        push("sb_clr", 6, 32'h0);
        push("sb_after", 0, 32'h55);
        check();

        // Set/clear collision on x9
        aiss(5'd9);
        awr(0, 5'd9, 32'h99);
        tick();
        ard(0, 5'd9);
        #1;
        push("coll_bvec", 6, 32'h0000_0200);
        push("coll_data", 0, 32'h99);
        push("coll_busy", 3, 32'h1);
        check();

        // Two write ports to x4, three readers
        awr(0, 5'd4, 32'hA);
        awr(1, 5'd4, 32'hB);
        ard(0, 5'd4);
        ard(1, 5'd0);
        ard(2, 5'd4);
        #1;
        push("mp_byp0", 0, 32'hB);
        push("mp_byp1", 1, 32'h0);
        push("mp_byp2", 2, 32'hB);
        check();
        tick();
        ard(0, 5'd4);
        ard(1, 5'd0);
        ard(2, 5'd4);
        #1;
        push("mp_st0", 0, 32'hB);
        push("mp_st1", 1, 32'h0);
        push("mp_st2", 2, 32'hB);
        check();

        // Re-issue to a busy register
        aiss(5'd9);
        tick();
        #1;
        push("waw_bvec", 6, 32'h0000_0200);
        check();

        // Reset mid-operation
        awr(0, 5'd5, 32'hDEAD_BEEF);
        aiss(5'd7);
        tick();
        ard(0, 5'd5);
        #1;
        push("pre_rst_data", 0, 32'hDEAD_BEEF);
        push("pre_rst_bvec", 6, 32'h0000_0280);
        check();
        rst = 1'b1;
        awr(0, 5'd6, 32'h66);
        ard(1, 5'd6);
        #1;
        push("arst_data", 0, 32'h0);
        push("arst_bvec", 6, 32'h0);
        push("arst_byp", 1, 32'h0);
        push("arst_x3", 7, 32'h0);
        check();
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle();
        ard(0, 5'd6);
        ard(1, 5'd3);
        #1;
        push("rst_prio", 0, 32'h0);
        push("rst_x3", 1, 32'h0);
        push("rst_bvec2", 6, 32'h0);
        check();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the RV32I pipeline core, successor to the single-write/dual-read bank.
- Adds configurable read/write port counts and write-to-read bypass (removes the write-then-read half-cycle hazard).
- Adds a per-register busy scoreboard, set at issue and cleared at writeback, so decode can detect RAW hazards.
- Sits between decode (read ports, issue port) and writeback (write ports).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >=2.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports; 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only.
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy.
- Derived localparam AW = $clog2(NREGS).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*AW  packed read addresses; port p uses bits [p*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational.
- rd_busy  out  NRD  scoreboard busy flag of each read address, combinational.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  packed write addresses.
- wr_data  in  NWR*XLEN  packed write data.
- iss_en  in  1  issue strobe; marks iss_addr as pending.
- iss_addr  in  AW  destination register of the issuing instruction.
- busy_vec  out  NREGS  full scoreboard state, registered.

Behaviour:
- Reset (async, rst=1): all registers = 0, all busy bits = 0. Consequently rd_data = 0, rd_busy = 0, busy_vec = 0 while rst is held. Reset has priority over any write or issue in the same cycle.
- Write: on the rising edge, for each port w with wr_en[w]=1, regs[wr_addr[w]] <= wr_data[w].
  - Two ports writing the same address in one cycle: the highest-indexed port wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational, 0-cycle latency): rd_data[p] = regs[rd_addr[p]].
  - With BYPASS=1, if any enabled write port targets rd_addr[p] this cycle, rd_data[p] returns that port's wr_data instead; the highest-indexed matching port wins.
  - With ZERO_REG=1, address 0 always reads 0, bypass ignored.
- Scoreboard:
  - Clear: busy[a] <= 0 for every enabled write address a.
  - Set: busy[iss_addr] <= 1 when iss_en=1.
  - Same register both set and cleared in one cycle: set wins (the new producer is outstanding).
  - iss_en to address 0 with ZERO_REG=1: ignored.
  - Issue to an already-busy register: remains busy (WAW is not tracked; the count does not nest).
- rd_busy[p] = busy[rd_addr[p]].
  - With BYPASS=1, forced to 0 when an enabled write port targets rd_addr[p] this cycle, since the data is forwarded.
  - With ZERO_REG=1, rd_busy = 0 for address 0.
- busy_vec reflects registered state only; it does not include same-cycle bypass.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Decomposition:
- Shared package rv_pkg: XLEN default, NREGS default, REG_ZERO constant, plus the function that unpacks a port slice from a packed address or data bus.
- One natural sub-module, regfile_sb_core: the busy-bit array with its set/clear priority logic. It is instantiated once and verifiable standalone.
- Storage and bypass muxing stay in the top module.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to x5 and issue x7, then pulse rst asynchronously between edges → rd_data for x5 = 0 and busy_vec = 0 immediately, before the next edge.
- Bypass: wr_en=1, x3 ← 0x12345678, rd_addr0=3 in the same cycle → rd_data0 = 0x12345678 and rd_busy0 = 0 with BYPASS=1; with BYPASS=0, rd_data0 = old value 0 and it updates on the next cycle.
- Zero register: write 0xFFFFFFFF to x0 and iss_en to x0 → rd_data for x0 = 0, busy_vec[0] = 0.
- Scoreboard lifecycle: issue x10 at cycle 1 → busy_vec[10]=1 from cycle 2. Write x10 ← 0x55 at cycle 4 → busy cleared at cycle 5, and a read at cycle 4 returns 0x55 with rd_busy=0.
- Set/clear collision: issue x9 and write x9 in the same cycle → x9 holds the new data and busy_vec[9] = 1 afterwards.
- Multi-port conflict (NWR=2): port0 x4 ← 0xA, port1 x4 ← 0xB in the same cycle → x4 = 0xB, and the bypassed read returns 0xB. Also, NRD=3 reading x4, x0 and x4 simultaneously returns 0xB, 0, 0xB.
